// File: rtl/alu_operand_stage.sv
// alu_operand_stage: GPR read/issue stage feeding the ALU, with writeback bypass and a RAW-hazard scoreboard.
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [2:0]    in_op,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [2:0]    ALUOp,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);
  logic [DW-1:0] gpr [NREG];
  logic [NREG-1:0] pending, pending_nxt;
  logic [DW-1:0] a_val, b_val;
  logic rs_byp, rt_byp, haz, take;
  assign rs_byp = wb_en && wb_addr == in_rs;
  assign rt_byp = wb_en && wb_addr == in_rt;
  assign a_val = in_rs == '0 ? '0 : rs_byp ? wb_data : gpr[in_rs];
  assign b_val = in_use_imm ? in_imm : in_rt == '0 ? '0 : rt_byp ? wb_data : gpr[in_rt];
  // a writeback arriving this cycle resolves the dependency through the bypass
  assign haz = (in_rs != '0 && pending[in_rs] && !rs_byp)
             || (!in_use_imm && in_rt != '0 && pending[in_rt] && !rt_byp);
  assign in_ready = (!out_valid || out_ready) && !haz;
  assign take = in_valid && in_ready;
  // set after clear so a newly issued producer wins over a retiring one
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (take && in_rd != '0) pending_nxt[in_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A <= '0;
      B <= '0;
      ALUOp <= '0;
      out_rd <= '0;
      pending <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      if (take) begin
        A <= a_val;
        B <= b_val;
        ALUOp <= in_op;
        out_rd <= in_rd;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wb_en && wb_addr != '0) gpr[wb_addr] <= wb_data;
      pending <= pending_nxt;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed issue/hazard/writeback sequence with a queue scoreboard on the output slot.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [2:0] in_op = '0;
  logic in_use_imm = 1'b0;
  logic [31:0] in_imm = '0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] A, B;
  logic [2:0] ALUOp;
  logic [4:0] out_rd;
  logic wb_en = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  int total = 0, bad = 0;

  typedef struct packed {logic [31:0] a, b; logic [2:0] op; logic [4:0] rd;} exp_t;
  exp_t sb[$];
  logic [31:0] mgpr [32];

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .ALUOp(ALUOp), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mval(input logic [4:0] r);
    return r == 0 ? 32'h0 : (wb_en && wb_addr == r) ? wb_data : mgpr[r];
  endfunction

  // Reference model sampled mid-cycle: decisions here apply at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < 32; i++) mgpr[i] = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_empty observed=out_valid expected=no_output");
        end else begin
          e = sb.pop_front();
          chk("sb_A", A, e.a);
          chk("sb_B", B, e.b);
          chk("sb_op", {29'b0, ALUOp}, {29'b0, e.op});
          chk("sb_rd", {27'b0, out_rd}, {27'b0, e.rd});
        end
      end
      if (in_valid && in_ready)
        sb.push_back({mval(in_rs), in_use_imm ? in_imm : mval(in_rt), in_op, in_rd});
      if (wb_en && wb_addr != 0) mgpr[wb_addr] = wb_data;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, rt, rd, input logic [2:0] op,
                       input logic imm_sel, input logic [31:0] imm);
    in_valid = 1'b1;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
    in_op = op;
    in_use_imm = imm_sel;
    in_imm = imm;
  endtask

  task automatic issue(input logic [4:0] rs, rt, rd, input logic [2:0] op,
                       input logic imm_sel, input logic [31:0] imm);
    int n;
    drive(rs, rt, rd, op, imm_sel, imm);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", {31'b0, in_ready}, 32'd1);
    go();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  initial begin
    repeat (2) go();
    rst_n = 1'b1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    // basic immediate issue
    wb(5'd5, 32'h0000_00A5);
    go();
    wb_en = 1'b0;
    issue(5'd5, 5'd0, 5'd0, 3'b000, 1'b1, 32'hFFFF_FFF0);
    chk("imm_valid", {31'b0, out_valid}, 32'd1);
    chk("imm_A", A, 32'h0000_00A5);
    chk("imm_B", B, 32'hFFFF_FFF0);
    chk("imm_op", {29'b0, ALUOp}, 32'd0);
    // RAW on r7 resolved by bypass
    issue(5'd0, 5'd0, 5'd7, 3'b010, 1'b1, 32'd1);
    drive(5'd7, 5'd0, 5'd0, 3'b001, 1'b1, 32'd0);
    @(negedge clk);
    chk("raw_stall0", {31'b0, in_ready}, 32'd0);
    go();
    @(negedge clk);
    chk("raw_stall1", {31'b0, in_ready}, 32'd0);
    go();
    wb(5'd7, 32'h1234);
    #1;
    chk("raw_release", {31'b0, in_ready}, 32'd1);
    go();
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("raw_byp_A", A, 32'h1234);
    drive(5'd7, 5'd0, 5'd0, 3'b001, 1'b1, 32'd0);
    #1;
    chk("raw_cleared", {31'b0, in_ready}, 32'd1);
    go();
    in_valid = 1'b0;
    chk("raw_gpr_A", A, 32'h1234);
    // output backpressure
    drive(5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 32'h11);
    #1;
    chk("bp_first", {31'b0, in_ready}, 32'd1);
    go();
    out_ready = 1'b0;
    drive(5'd5, 5'd0, 5'd0, 3'b010, 1'b1, 32'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_B", B, 32'h11);
      chk("bp_op", {29'b0, ALUOp}, 32'd1);
      go();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, in_ready}, 32'd1);
    go();
    in_valid = 1'b0;
    chk("bp_swap_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_swap_B", B, 32'h22);
    chk("bp_swap_op", {29'b0, ALUOp}, 32'd2);
    // register 0: writes dropped, rd=0 never creates a dependency
    wb(5'd0, 32'hDEAD);
    drive(5'd0, 5'd0, 5'd0, 3'b011, 1'b0, 32'h0);
    #1;
    chk("r0_ready", {31'b0, in_ready}, 32'd1);
    go();
    wb_en = 1'b0;
    chk("r0_A", A, 32'd0);
    chk("r0_B", B, 32'd0);
    @(negedge clk);
    chk("r0_nostall", {31'b0, in_ready}, 32'd1);
    go();
    in_valid = 1'b0;
    chk("r0_B2", B, 32'd0);
    // same-cycle set and clear of pending[9]
    wb(5'd9, 32'h99);
    drive(5'd0, 5'd0, 5'd9, 3'b100, 1'b1, 32'h5);
    #1;
    chk("sc_ready", {31'b0, in_ready}, 32'd1);
    go();
    wb_en = 1'b0;
    drive(5'd9, 5'd0, 5'd0, 3'b101, 1'b1, 32'h6);
    #1;
    chk("sc_stall0", {31'b0, in_ready}, 32'd0);
    go();
    chk("sc_stall1", {31'b0, in_ready}, 32'd0);
    wb(5'd9, 32'h77);
    #1;
    chk("sc_release", {31'b0, in_ready}, 32'd1);
    go();
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("sc_A", A, 32'h77);
    // rt hazard only matters when B comes from the register file
    issue(5'd0, 5'd0, 5'd12, 3'b110, 1'b1, 32'h7);
    drive(5'd0, 5'd12, 5'd0, 3'b000, 1'b0, 32'h0);
    #1;
    chk("rt_stall", {31'b0, in_ready}, 32'd0);
    in_use_imm = 1'b1;
    #1;
    chk("rt_imm_ok", {31'b0, in_ready}, 32'd1);
    go();
    in_valid = 1'b0;
    wb(5'd12, 32'hC);
    go();
    wb_en = 1'b0;
    // asynchronous reset with a held slot and an outstanding producer
    wb(5'd3, 32'h33);
    go();
    wb_en = 1'b0;
    drive(5'd3, 5'd0, 5'd4, 3'b110, 1'b1, 32'h44);
    go();
    in_valid = 1'b0;
    out_ready = 1'b0;
    go();
    chk("pre_rst_A", A, 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_A", A, 32'd0);
    chk("arst_B", B, 32'd0);
    chk("arst_op", {29'b0, ALUOp}, 32'd0);
    chk("arst_rd", {27'b0, out_rd}, 32'd0);
    @(negedge clk);
    go();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(5'(i), 5'(32 - i), 5'd0, 3'b111, 1'b0, 32'h0);
      #1;
      chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
      go();
    end
    in_valid = 1'b0;
    repeat (3) go();
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
